// File: rtl/risc_prog_loader.sv
// risc_prog_loader: loads framed byte stream into instruction memory, checks XOR sum, then releases the core.
module risc_prog_loader #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              halt,
    output logic              inst_we,
    output logic [ADDR_W-1:0] inst_address,
    output logic [DATA_W-1:0] inst_data,
    output logic              cpu_rst_n,
    output logic              cpu_running,
    output logic              done,
    output logic              err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (DATA_W > ADDR_W ? DATA_W : ADDR_W) + 1;
    typedef enum logic [2:0] {S_HDR, S_LEN, S_DATA, S_CSUM, S_RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, inst_address_q, inst_address_d;
    logic [DATA_W-1:0] csum_q, csum_d, inst_data_q, inst_data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              run_q, run_d, inst_we_q, inst_we_d, done_q, done_d, err_q, err_d;
    logic              xfer, in_frame;
    assign in_ready     = state_q != S_RUN;
    assign cpu_rst_n    = state_q == S_RUN;
    assign cpu_running  = state_q == S_RUN;
    assign inst_we      = inst_we_q;
    assign inst_address = inst_address_q;
    assign inst_data    = inst_data_q;
    assign done         = done_q;
    assign err          = err_q;
    always_comb begin
        xfer           = in_valid && in_ready;
        in_frame       = state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM;
        state_d        = state_q;
        addr_d         = addr_q;
        run_d          = run_q;
        csum_d         = csum_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        inst_we_d      = 1'b0;
        inst_address_d = inst_address_q;
        inst_data_d    = inst_data_q;
        done_d         = 1'b0;
        tmo_d          = (!in_frame || xfer) ? '0 : tmo_q + 1'b1;
        case (state_q)
            S_HDR: if (xfer) begin
                addr_d  = in_data[ADDR_W-1:0];
                run_d   = in_data[DATA_W-1];
                csum_d  = '0;
                err_d   = 1'b0;
                state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
                cnt_d   = (in_data == '0) ? CW'(1) << ADDR_W : CW'(in_data);
                state_d = S_DATA;
            end
            S_DATA: if (xfer) begin
                inst_we_d      = 1'b1;
                inst_address_d = addr_q;
                inst_data_d    = in_data;
                addr_d         = addr_q + 1'b1;
                csum_d         = csum_q ^ in_data;
                cnt_d          = cnt_q - 1'b1;
                state_d        = (cnt_q == CW'(1)) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (xfer) begin
                done_d  = 1'b1;
                err_d   = in_data != csum_q;
                state_d = (in_data == csum_q && run_q) ? S_RUN : S_HDR;
            end
            S_RUN: if (halt) state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
        // a stalled frame is abandoned; writes already issued stay in memory
        if (in_frame && !xfer && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_HDR;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HDR;
            addr_q         <= '0;
            run_q          <= 1'b0;
            csum_q         <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            err_q          <= 1'b0;
            inst_we_q      <= 1'b0;
            inst_address_q <= '0;
            inst_data_q    <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            run_q          <= run_d;
            csum_q         <= csum_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            err_q          <= err_d;
            inst_we_q      <= inst_we_d;
            inst_address_q <= inst_address_d;
            inst_data_q    <= inst_data_d;
            done_q         <= done_d;
        end
    end
endmodule
